rob_multi_wb: RTL and testbench

//  Parametrised reorder buffer for the out-of-order RV32I core. Allocates one entry per dispatched instruction.

---
 rtl/rob_multi_wb_pkg.sv | 24 ++
 rtl/rob_wb_merge.sv | 32 +++
 rtl/rob_multi_wb.sv | 150 +++++++++++++++
 tb/tb_rob_multi_wb.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_multi_wb_pkg.sv
// Shared types for the multi-writeback reorder buffer: default sizes and the
// per-entry payload structs used by the ROB and its writeback merge logic.
package rob_multi_wb_pkg;

  localparam int XLEN              = 32;
  localparam int ARCH_REG_BITS     = 5;
  localparam int NUM_WB_PORTS      = 2;
  localparam int DEF_ROB_NUM_BITS  = 4;
  localparam int DEF_PHYS_REG_BITS = 6;

  // Result fields a writeback channel delivers into an entry.
  typedef struct packed {
    logic            mispredict;
    logic [XLEN-1:0] rd_data;
    logic [XLEN-1:0] br_target;
  } rob_result_t;

  // Fields captured at dispatch time.
  typedef struct packed {
    logic [XLEN-1:0]          pc;
    logic [ARCH_REG_BITS-1:0] rd_addr;
  } rob_info_t;

endpackage

// File: rtl/rob_wb_merge.sv
// Per-entry writeback select: for every ROB entry, picks the result of the
// highest-indexed writeback channel that targets it this cycle.
module rob_wb_merge
  import rob_multi_wb_pkg::*;
#(
  parameter int ROB_NUM_BITS = DEF_ROB_NUM_BITS,
  parameter int NUM_WB       = NUM_WB_PORTS
) (
  input  logic        [NUM_WB-1:0]                   i_wb_valid,
  input  logic        [NUM_WB-1:0][ROB_NUM_BITS-1:0] i_wb_addr,
  input  rob_result_t [NUM_WB-1:0]                   i_wb_res,
  output logic        [(1<<ROB_NUM_BITS)-1:0]        o_hit,
  output rob_result_t [(1<<ROB_NUM_BITS)-1:0]        o_res
);

  localparam int DEPTH = 1 << ROB_NUM_BITS;

  // Later channels overwrite earlier ones, so the highest index wins a collision.
  always_comb begin
    o_hit = '0;
    o_res = '0;
    for (int e = 0; e < DEPTH; e++) begin
      for (int c = 0; c < NUM_WB; c++) begin
        if (i_wb_valid[c] && (i_wb_addr[c] == ROB_NUM_BITS'(e))) begin
          o_hit[e] = 1'b1;
          o_res[e] = i_wb_res[c];
        end
      end
    end
  end

endmodule

// File: rtl/rob_multi_wb.sv
// Reorder buffer with NUM_WB writeback channels: in-order allocate and retire,
// out-of-order completion, and a one-cycle flush after a mispredicted commit.
module rob_multi_wb
  import rob_multi_wb_pkg::*;
#(
  parameter int ROB_NUM_BITS  = DEF_ROB_NUM_BITS,
  parameter int PHYS_REG_BITS = DEF_PHYS_REG_BITS,
  parameter int NUM_WB        = NUM_WB_PORTS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           dispatch_valid,
  output logic                           dispatch_ready,
  input  logic [XLEN-1:0]                dispatch_pc,
  input  logic [ARCH_REG_BITS-1:0]       dispatch_rd_addr,
  input  logic [PHYS_REG_BITS-1:0]       dispatch_rd_paddr,
  output logic [ROB_NUM_BITS-1:0]        dispatch_rob_addr,
  input  logic [NUM_WB-1:0]              wb_valid,
  input  logic [NUM_WB*ROB_NUM_BITS-1:0] wb_rob_addr,
  input  logic [NUM_WB*XLEN-1:0]         wb_rd_data,
  input  logic [NUM_WB-1:0]              wb_mispredict,
  input  logic [NUM_WB*XLEN-1:0]         wb_br_target,
  output logic                           commit_valid,
  input  logic                           commit_ready,
  output logic [XLEN-1:0]                commit_pc,
  output logic [ARCH_REG_BITS-1:0]       commit_rd_addr,
  output logic [PHYS_REG_BITS-1:0]       commit_rd_paddr,
  output logic [XLEN-1:0]                commit_rd_data,
  output logic                           flush,
  output logic [XLEN-1:0]                flush_pc,
  output logic [ROB_NUM_BITS:0]          occupancy
);

  localparam int DEPTH = 1 << ROB_NUM_BITS;
  localparam int PTR_W = ROB_NUM_BITS + 1;

  logic [PTR_W-1:0]         r_head;
  logic [PTR_W-1:0]         r_tail;
  logic [DEPTH-1:0]         r_valid;
  logic [DEPTH-1:0]         r_done;
  rob_info_t                r_info  [DEPTH];
  logic [PHYS_REG_BITS-1:0] r_paddr [DEPTH];
  rob_result_t              r_res   [DEPTH];
  logic                     r_flush;
  logic [XLEN-1:0]          r_flush_pc;

  logic [ROB_NUM_BITS-1:0]               w_head_idx;
  logic [ROB_NUM_BITS-1:0]               w_tail_idx;
  logic                                  w_full;
  logic                                  w_dispatch;
  logic                                  w_commit;
  logic                                  w_mispredict_commit;
  logic [NUM_WB-1:0][ROB_NUM_BITS-1:0]   w_wb_addr;
  rob_result_t [NUM_WB-1:0]              w_wb_res;
  logic [DEPTH-1:0]                      w_wb_hit;
  rob_result_t [DEPTH-1:0]               w_wb_sel;

  assign w_head_idx = r_head[ROB_NUM_BITS-1:0];
  assign w_tail_idx = r_tail[ROB_NUM_BITS-1:0];
  assign w_full     = (w_head_idx == w_tail_idx) &&
                      (r_head[ROB_NUM_BITS] != r_tail[ROB_NUM_BITS]);

  assign dispatch_ready      = !w_full && !r_flush;
  assign dispatch_rob_addr   = w_tail_idx;
  assign w_dispatch          = dispatch_valid && dispatch_ready;
  assign commit_valid        = r_valid[w_head_idx] && r_done[w_head_idx];
  assign w_commit            = commit_valid && commit_ready;
  assign w_mispredict_commit = w_commit && r_res[w_head_idx].mispredict;

  assign commit_pc       = r_info[w_head_idx].pc;
  assign commit_rd_addr  = r_info[w_head_idx].rd_addr;
  assign commit_rd_paddr = r_paddr[w_head_idx];
  assign commit_rd_data  = r_res[w_head_idx].rd_data;
  assign flush           = r_flush;
  assign flush_pc        = r_flush_pc;
  assign occupancy       = r_tail - r_head;

  // The flat channel buses are regrouped per channel before the per-entry select.
  assign w_wb_addr = wb_rob_addr;
  always_comb begin
    for (int c = 0; c < NUM_WB; c++) begin
      w_wb_res[c].mispredict = wb_mispredict[c];
      w_wb_res[c].rd_data    = wb_rd_data[c*XLEN +: XLEN];
      w_wb_res[c].br_target  = wb_br_target[c*XLEN +: XLEN];
    end
  end

  rob_wb_merge #(
    .ROB_NUM_BITS(ROB_NUM_BITS),
    .NUM_WB      (NUM_WB)
  ) u_merge (
    .i_wb_valid(wb_valid),
    .i_wb_addr (w_wb_addr),
    .i_wb_res  (w_wb_res),
    .o_hit     (w_wb_hit),
    .o_res     (w_wb_sel)
  );

  // Mispredicted commit overrides everything else: all entries die and tail
  // lands on the new head, so a same-cycle dispatch is discarded too.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_valid    <= '0;
      r_done     <= '0;
      r_flush    <= 1'b0;
      r_flush_pc <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (w_wb_hit[e] && r_valid[e]) r_done[e] <= 1'b1;
      end
      if (w_dispatch) begin
        r_valid[w_tail_idx] <= 1'b1;
        r_done[w_tail_idx]  <= 1'b0;
        r_tail              <= r_tail + PTR_W'(1);
      end
      if (w_commit) begin
        r_valid[w_head_idx] <= 1'b0;
        r_done[w_head_idx]  <= 1'b0;
        r_head              <= r_head + PTR_W'(1);
      end
      if (w_mispredict_commit) begin
        r_valid <= '0;
        r_tail  <= r_head + PTR_W'(1);
      end
      r_flush <= w_mispredict_commit;
      if (w_mispredict_commit) r_flush_pc <= r_res[w_head_idx].br_target;
    end
  end

  // Payload storage needs no reset; valid/done gate every use of it.
  always_ff @(posedge clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (w_wb_hit[e] && r_valid[e]) r_res[e] <= w_wb_sel[e];
    end
    if (w_dispatch) begin
      r_info[w_tail_idx]  <= '{pc: dispatch_pc, rd_addr: dispatch_rd_addr};
      r_paddr[w_tail_idx] <= dispatch_rd_paddr;
    end
  end

  for (genvar i = 0; i < NUM_WB; i++) begin : g_wb_a
    for (genvar j = i + 1; j < NUM_WB; j++) begin : g_wb_b
      a_wb_collision: assert property (@(posedge clk) disable iff (rst)
        !(wb_valid[i] && wb_valid[j] && (w_wb_addr[i] == w_wb_addr[j])));
    end
  end

endmodule

// File: tb/tb_rob_multi_wb.sv
// Directed bench for rob_multi_wb: stimulus queues expected commits/flushes,
// a negedge monitor pops and compares whatever the ROB presents.
module tb_rob_multi_wb;

  localparam int RB = 4;
  localparam int PB = 6;
  localparam int NW = 2;

  logic              clk;
  logic              rst;
  logic              dispatch_valid;
  logic              dispatch_ready;
  logic [31:0]       dispatch_pc;
  logic [4:0]        dispatch_rd_addr;
  logic [PB-1:0]     dispatch_rd_paddr;
  logic [RB-1:0]     dispatch_rob_addr;
  logic [NW-1:0]     wb_valid;
  logic [NW*RB-1:0]  wb_rob_addr;
  logic [NW*32-1:0]  wb_rd_data;
  logic [NW-1:0]     wb_mispredict;
  logic [NW*32-1:0]  wb_br_target;
  logic              commit_valid;
  logic              commit_ready;
  logic [31:0]       commit_pc;
  logic [4:0]        commit_rd_addr;
  logic [PB-1:0]     commit_rd_paddr;
  logic [31:0]       commit_rd_data;
  logic              flush;
  logic [31:0]       flush_pc;
  logic [RB:0]       occupancy;

  rob_multi_wb #(
    .ROB_NUM_BITS (RB),
    .PHYS_REG_BITS(PB),
    .NUM_WB       (NW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .dispatch_valid   (dispatch_valid),
    .dispatch_ready   (dispatch_ready),
    .dispatch_pc      (dispatch_pc),
    .dispatch_rd_addr (dispatch_rd_addr),
    .dispatch_rd_paddr(dispatch_rd_paddr),
    .dispatch_rob_addr(dispatch_rob_addr),
    .wb_valid         (wb_valid),
    .wb_rob_addr      (wb_rob_addr),
    .wb_rd_data       (wb_rd_data),
    .wb_mispredict    (wb_mispredict),
    .wb_br_target     (wb_br_target),
    .commit_valid     (commit_valid),
    .commit_ready     (commit_ready),
    .commit_pc        (commit_pc),
    .commit_rd_addr   (commit_rd_addr),
    .commit_rd_paddr  (commit_rd_paddr),
    .commit_rd_data   (commit_rd_data),
    .flush            (flush),
    .flush_pc         (flush_pc),
    .occupancy        (occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [31:0]   pc;
    logic [4:0]    rd;
    logic [PB-1:0] prd;
    logic [31:0]   data;
  } ExpCommit;

  ExpCommit    expQ[$];
  logic [31:0] flushQ[$];
  int          nCompared = 0;
  int          nMismatched = 0;
  logic [31:0] robPc [16];
  logic [4:0]  mTail;
  int          nSeq;
  logic [3:0]  kIdx [20];

  function automatic logic [31:0] dataOf(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Clocks the staged inputs in, then returns one-shot inputs to idle.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    dispatch_valid = 1'b0;
    wb_valid       = '0;
    wb_mispredict  = '0;
  endtask

  task automatic dispatchInstr(input bit expectCommit);
    logic [31:0] pc;
    pc = 32'h0000_1000 + 32'(nSeq) * 4;
    dispatch_valid    = 1'b1;
    dispatch_pc       = pc;
    dispatch_rd_addr  = 5'(nSeq);
    dispatch_rd_paddr = PB'(nSeq + 8);
    if (expectCommit) expQ.push_back(ExpCommit'{pc: pc, rd: 5'(nSeq), prd: PB'(nSeq + 8), data: dataOf(pc)});
    robPc[mTail[3:0]] = pc;
    mTail++;
    nSeq++;
  endtask

  task automatic stageRefusedDispatch();
    dispatch_valid    = 1'b1;
    dispatch_pc       = 32'hDEAD_0000;
    dispatch_rd_addr  = 5'd31;
    dispatch_rd_paddr = PB'(63);
  endtask

  task automatic stageWb(input int ch, input logic [3:0] idx, input bit mp = 1'b0, input logic [31:0] tgt = 32'h0);
    wb_valid[ch]                = 1'b1;
    wb_rob_addr[ch*RB +: RB]    = idx;
    wb_rd_data[ch*32 +: 32]     = dataOf(robPc[idx]);
    wb_mispredict[ch]           = mp;
    wb_br_target[ch*32 +: 32]   = tgt;
  endtask

  always @(negedge clk) begin : monitor
    ExpCommit e;
    logic [31:0] fpc;
    if (!rst) begin
      if (commit_valid && commit_ready) begin
        if (expQ.size() == 0) begin
          nCompared++;
          nMismatched++;
          $display("[TB] FAIL commit_unexpected: got pc 0x%08h, expected no commit", commit_pc);
        end else begin
          e = expQ.pop_front();
          checkOutput("commit_pc", commit_pc, e.pc);
          checkOutput("commit_rd_addr", 32'(commit_rd_addr), 32'(e.rd));
          checkOutput("commit_rd_paddr", 32'(commit_rd_paddr), 32'(e.prd));
          checkOutput("commit_rd_data", commit_rd_data, e.data);
        end
      end
      if (flush) begin
        if (flushQ.size() == 0) begin
          nCompared++;
          nMismatched++;
          $display("[TB] FAIL flush_unexpected: got flush_pc 0x%08h, expected no flush", flush_pc);
        end else begin
          fpc = flushQ.pop_front();
          checkOutput("flush_pc", flush_pc, fpc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    dispatch_valid = 1'b0;
    dispatch_pc = '0;
    dispatch_rd_addr = '0;
    dispatch_rd_paddr = '0;
    wb_valid = '0;
    wb_rob_addr = '0;
    wb_rd_data = '0;
    wb_mispredict = '0;
    wb_br_target = '0;
    commit_ready = 1'b0;
    mTail = '0;
    nSeq = 0;
    for (int i = 0; i < 16; i++) robPc[i] = '0;

    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    checkOutput("reset_dispatch_ready", 32'(dispatch_ready), 32'd1);
    checkOutput("reset_commit_valid", 32'(commit_valid), 32'd0);
    checkOutput("reset_occupancy", 32'(occupancy), 32'd0);
    checkOutput("reset_rob_addr", 32'(dispatch_rob_addr), 32'd0);
    checkOutput("reset_flush", 32'(flush), 32'd0);

    // Fill to 16 with no retirement; the 17th request must bounce.
    for (int i = 0; i < 16; i++) begin
      checkOutput("fill_rob_addr", 32'(dispatch_rob_addr), 32'(i));
      dispatchInstr(1'b1);
      applyStimulus();
    end
    checkOutput("full_occupancy", 32'(occupancy), 32'd16);
    checkOutput("full_dispatch_ready", 32'(dispatch_ready), 32'd0);
    stageRefusedDispatch();
    applyStimulus();
    checkOutput("full_17th_occupancy", 32'(occupancy), 32'd16);
    checkOutput("full_commit_valid", 32'(commit_valid), 32'd0);

    // Out-of-order completion: 3 finishes early but must wait for 1 and 2.
    stageWb(0, 4'd3);
    stageWb(1, 4'd0);
    applyStimulus();
    checkOutput("ooo_head_ready", 32'(commit_valid), 32'd1);
    commit_ready = 1'b1;
    applyStimulus();
    checkOutput("ooo_entry3_waits", 32'(commit_valid), 32'd0);
    checkOutput("ooo_occupancy", 32'(occupancy), 32'd15);
    stageWb(0, 4'd1);
    stageWb(1, 4'd2);
    applyStimulus();
    repeat (3) applyStimulus();
    checkOutput("ooo_drain_occupancy", 32'(occupancy), 32'd12);
    checkOutput("ooo_drain_commit_valid", 32'(commit_valid), 32'd0);

    // Refill to full, then commit and dispatch in the same cycle.
    commit_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dispatchInstr(1'b1);
      applyStimulus();
    end
    checkOutput("refill_occupancy", 32'(occupancy), 32'd16);
    checkOutput("refill_dispatch_ready", 32'(dispatch_ready), 32'd0);
    stageWb(0, 4'd4);
    applyStimulus();
    checkOutput("refill_head_done", 32'(commit_valid), 32'd1);
    stageRefusedDispatch();
    commit_ready = 1'b1;
    applyStimulus();
    commit_ready = 1'b0;
    checkOutput("nobypass_occupancy", 32'(occupancy), 32'd15);
    checkOutput("nobypass_dispatch_ready", 32'(dispatch_ready), 32'd1);
    checkOutput("nobypass_rob_addr", 32'(dispatch_rob_addr), 32'd4);

    // Complete and drain the remaining 15 entries (indices 5..15, 0..3).
    commit_ready = 1'b1;
    for (int i = 0; i < 15; i += 2) begin
      stageWb(0, 4'(5 + i));
      if (i + 1 < 15) stageWb(1, 4'(6 + i));
      applyStimulus();
    end
    repeat (20) applyStimulus();
    checkOutput("drain_occupancy", 32'(occupancy), 32'd0);

    // Streaming: 20 dispatches with writeback two cycles behind; indices wrap 15->0.
    for (int k = 0; k < 20; k++) begin
      checkOutput("stream_dispatch_ready", 32'(dispatch_ready), 32'd1);
      checkOutput("stream_rob_addr", 32'(dispatch_rob_addr), 32'(mTail[3:0]));
      kIdx[k] = mTail[3:0];
      dispatchInstr(1'b1);
      if (k >= 2) stageWb(k % 2, kIdx[k-2]);
      applyStimulus();
    end
    stageWb(0, kIdx[18]);
    stageWb(1, kIdx[19]);
    applyStimulus();
    repeat (5) applyStimulus();
    checkOutput("stream_occupancy", 32'(occupancy), 32'd0);
    checkOutput("stream_commit_valid", 32'(commit_valid), 32'd0);

    // Reset mid-operation with 7 live entries discards them silently.
    commit_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      dispatchInstr(1'b0);
      applyStimulus();
    end
    checkOutput("prerst_occupancy", 32'(occupancy), 32'd7);
    rst = 1'b1;
    applyStimulus();
    checkOutput("midrst_occupancy", 32'(occupancy), 32'd0);
    checkOutput("midrst_commit_valid", 32'(commit_valid), 32'd0);
    checkOutput("midrst_flush", 32'(flush), 32'd0);
    checkOutput("midrst_rob_addr", 32'(dispatch_rob_addr), 32'd0);
    rst = 1'b0;
    mTail = '0;

    // Mispredict on entry 2: entries 3..5 are wrong-path and never retire.
    for (int i = 0; i < 6; i++) begin
      dispatchInstr(i < 3);
      applyStimulus();
    end
    commit_ready = 1'b1;
    stageWb(0, 4'd0);
    stageWb(1, 4'd1);
    applyStimulus();
    stageWb(0, 4'd2, 1'b1, 32'h8000_0100);
    flushQ.push_back(32'h8000_0100);
    stageWb(1, 4'd4);
    applyStimulus();
    applyStimulus();
    checkOutput("premisp_flush", 32'(flush), 32'd0);
    applyStimulus();
    mTail = 5'd3;
    checkOutput("misp_flush", 32'(flush), 32'd1);
    checkOutput("misp_flush_pc", flush_pc, 32'h8000_0100);
    checkOutput("misp_occupancy", 32'(occupancy), 32'd0);
    checkOutput("misp_dispatch_ready", 32'(dispatch_ready), 32'd0);
    checkOutput("misp_commit_valid", 32'(commit_valid), 32'd0);
    stageRefusedDispatch();
    stageWb(0, 4'd3);
    applyStimulus();
    checkOutput("postflush_flush", 32'(flush), 32'd0);
    checkOutput("postflush_occupancy", 32'(occupancy), 32'd0);
    checkOutput("postflush_rob_addr", 32'(dispatch_rob_addr), 32'd3);
    checkOutput("postflush_dispatch_ready", 32'(dispatch_ready), 32'd1);
    checkOutput("postflush_commit_valid", 32'(commit_valid), 32'd0);
    dispatchInstr(1'b1);
    applyStimulus();
    checkOutput("resume_not_done", 32'(commit_valid), 32'd0);
    stageWb(1, 4'd3);
    applyStimulus();
    checkOutput("resume_done", 32'(commit_valid), 32'd1);
    applyStimulus();
    checkOutput("resume_occupancy", 32'(occupancy), 32'd0);

    repeat (3) applyStimulus();
    checkOutput("pending_commits", 32'(expQ.size()), 32'd0);
    checkOutput("pending_flushes", 32'(flushQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
